sb_tx_arbiter: RTL and testbench

// Shares the single sideband serializer among three requesters: the pattern generator, the RDI

---
 rtl/sb_tx_arbiter.sv | 223 ++++++++++++++++++++++
 tb/tb_sb_tx_arbiter.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sb_tx_arbiter.sv
// ---------------------------------------------------------------------------
// sb_tx_arbiter
//
// Shares the single sideband serializer among three packet sources: the
// pattern generator, the RDI message encoder and the LTSM message encoder.
// One packet is granted at a time. Its 64-bit words (header, then an
// optional data word, or a run of pattern words) are handed to the
// serializer one by one. A fixed idle gap is kept between packets.
//
// Parameters
//   GAP_CYCLES     idle cycles spent in GAP after the last i_ser_done (0..15)
//   PATTERN_WORDS  words per pattern burst (1..15)
//   PATTERN_WORD   content of every pattern word
//
// Ports
//   i_clk, i_rst_n          clock, asynchronous active-low reset
//   i_pat_req / o_pat_ack   pattern burst request (level) / done pulse
//   i_rdi_req / i_rdi_hdr   RDI header-only message request and header
//   o_rdi_ack               RDI packet done pulse
//   i_ltsm_req              LTSM message request (level)
//   i_ltsm_has_data         send i_ltsm_data after the header
//   i_ltsm_hdr/i_ltsm_data  LTSM header and data words
//   o_ltsm_ack              LTSM packet done pulse
//   o_ser_data              word presented to the serializer, held until done
//   o_ser_valid             1-cycle pulse marking a new o_ser_data word
//   i_ser_done              serializer finished shifting the current word
//   o_busy                  high whenever the FSM is not idle
// ---------------------------------------------------------------------------
module sb_tx_arbiter #(
  parameter int unsigned GAP_CYCLES    = 4,
  parameter int unsigned PATTERN_WORDS = 2,
  parameter logic [63:0] PATTERN_WORD  = 64'hAAAA_AAAA_AAAA_AAAA
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_pat_req,
  output logic        o_pat_ack,
  input  logic        i_rdi_req,
  input  logic [63:0] i_rdi_hdr,
  output logic        o_rdi_ack,
  input  logic        i_ltsm_req,
  input  logic        i_ltsm_has_data,
  input  logic [63:0] i_ltsm_hdr,
  input  logic [63:0] i_ltsm_data,
  output logic        o_ltsm_ack,
  output logic [63:0] o_ser_data,
  output logic        o_ser_valid,
  input  logic        i_ser_done,
  output logic        o_busy
);

  // FSM encoding
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SEND = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;
  localparam logic [1:0] ST_GAP  = 2'd3;

  // Owner of the packet in flight
  localparam logic [1:0] SRC_NONE = 2'd0;
  localparam logic [1:0] SRC_PAT  = 2'd1;
  localparam logic [1:0] SRC_RDI  = 2'd2;
  localparam logic [1:0] SRC_LTSM = 2'd3;

  localparam logic [3:0] PAT_COUNT = 4'(PATTERN_WORDS);
  localparam logic [3:0] GAP_LAST  = (GAP_CYCLES == 0) ? 4'd0 : 4'(GAP_CYCLES - 1);
  localparam bit         NO_GAP    = (GAP_CYCLES == 0);

  logic [1:0]  state;
  logic [1:0]  state_nxt;
  logic [1:0]  src;
  logic        rr_ltsm;      // 0: RDI wins an RDI/LTSM tie, 1: LTSM wins
  logic [3:0]  word_total;   // words in the packet, fixed at grant
  logic [3:0]  word_cnt;     // words already presented to the serializer
  logic [3:0]  gap_cnt;
  logic [63:0] next_word;    // every word after the first, captured at grant

  logic any_req;
  logic grant_pat;
  logic grant_rdi;
  logic grant_ltsm;
  logic word_done;
  logic last_word;
  logic pkt_end;

  // Arbitration: pattern has absolute priority; RDI and LTSM share the
  // remaining slots through the round-robin pointer.
  always_comb begin
    any_req    = i_pat_req | i_rdi_req | i_ltsm_req;
    grant_pat  = i_pat_req;
    grant_rdi  = !i_pat_req && i_rdi_req  && (!i_ltsm_req || !rr_ltsm);
    grant_ltsm = !i_pat_req && i_ltsm_req && (!i_rdi_req  ||  rr_ltsm);
  end

  // Completion of the current word and of the whole packet. i_ser_done
  // only counts while waiting on a word, so it is ignored in IDLE, SEND
  // and GAP.
  always_comb begin
    word_done = (state == ST_WAIT) && i_ser_done;
    last_word = (word_cnt == word_total);
    pkt_end   = word_done && last_word;
  end

  // Acks are combinational so they coincide with the final i_ser_done.
  // The FSM is forced to IDLE by reset, which keeps them low then.
  always_comb begin
    o_pat_ack  = pkt_end && (src == SRC_PAT);
    o_rdi_ack  = pkt_end && (src == SRC_RDI);
    o_ltsm_ack = pkt_end && (src == SRC_LTSM);
    o_busy     = (state != ST_IDLE);
  end

  // Next-state logic. A packet ending with GAP_CYCLES=0 returns straight
  // to IDLE, so the next grant still sees one idle cycle.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (any_req) begin
          state_nxt = ST_SEND;
        end
      end
      ST_SEND: begin
        state_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        if (word_done) begin
          if (!last_word) begin
            state_nxt = ST_SEND;
          end else if (NO_GAP) begin
            state_nxt = ST_IDLE;
          end else begin
            state_nxt = ST_GAP;
          end
        end
      end
      ST_GAP: begin
        if (gap_cnt == GAP_LAST) begin
          state_nxt = ST_IDLE;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Gap counter: restarts from zero on every entry into GAP and counts
  // the cycles spent there.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      gap_cnt <= 4'd0;
    end else if (state == ST_GAP && state_nxt == ST_GAP) begin
      gap_cnt <= gap_cnt + 4'd1;
    end else begin
      gap_cnt <= 4'd0;
    end
  end

  // Grant and word sequencing. The first word goes straight into
  // o_ser_data at grant. Any later word is captured into next_word at the
  // same moment, so the requester may change or drop its inputs while the
  // packet is in flight. o_ser_valid is high only in the cycle after a
  // word is loaded.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      src         <= SRC_NONE;
      rr_ltsm     <= 1'b0;
      word_total  <= 4'd0;
      word_cnt    <= 4'd0;
      next_word   <= 64'd0;
      o_ser_data  <= 64'd0;
      o_ser_valid <= 1'b0;
    end else begin
      o_ser_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (grant_pat) begin
            src         <= SRC_PAT;
            word_total  <= PAT_COUNT;
            word_cnt    <= 4'd1;
            o_ser_data  <= PATTERN_WORD;
            next_word   <= PATTERN_WORD;
            o_ser_valid <= 1'b1;
          end else if (grant_rdi) begin
            src         <= SRC_RDI;
            word_total  <= 4'd1;
            word_cnt    <= 4'd1;
            o_ser_data  <= i_rdi_hdr;
            next_word   <= 64'd0;
            o_ser_valid <= 1'b1;
            rr_ltsm     <= 1'b1;
          end else if (grant_ltsm) begin
            src         <= SRC_LTSM;
            word_total  <= i_ltsm_has_data ? 4'd2 : 4'd1;
            word_cnt    <= 4'd1;
            o_ser_data  <= i_ltsm_hdr;
            next_word   <= i_ltsm_data;
            o_ser_valid <= 1'b1;
            rr_ltsm     <= 1'b0;
          end
        end
        ST_WAIT: begin
          if (word_done && !last_word) begin
            word_cnt    <= word_cnt + 4'd1;
            o_ser_data  <= next_word;
            o_ser_valid <= 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sb_tx_arbiter.sv
// ---------------------------------------------------------------------------
// tb_sb_tx_arbiter
//
// Self-checking bench for sb_tx_arbiter. The bench plays the serializer
// (i_ser_done after a random delay) and the three requesters. It predicts
// the winner of each arbitration from the priority and round-robin rules,
// and derives each packet's word list from the request contents.
// ---------------------------------------------------------------------------
module tb_sb_tx_arbiter;

  localparam int          GAP  = 4;
  localparam int          PW   = 2;
  localparam logic [63:0] PWORD = 64'hAAAA_AAAA_AAAA_AAAA;

  localparam int SRC_PAT  = 0;
  localparam int SRC_RDI  = 1;
  localparam int SRC_LTSM = 2;
  localparam int SRC_NONE = 3;

  logic        i_clk;
  logic        i_rst_n;
  logic        i_pat_req;
  logic        o_pat_ack;
  logic        i_rdi_req;
  logic [63:0] i_rdi_hdr;
  logic        o_rdi_ack;
  logic        i_ltsm_req;
  logic        i_ltsm_has_data;
  logic [63:0] i_ltsm_hdr;
  logic [63:0] i_ltsm_data;
  logic        o_ltsm_ack;
  logic [63:0] o_ser_data;
  logic        o_ser_valid;
  logic        i_ser_done;
  logic        o_busy;

  int total = 0;
  int bad   = 0;
  int rrNext = SRC_RDI;

  sb_tx_arbiter #(
    .GAP_CYCLES(GAP),
    .PATTERN_WORDS(PW),
    .PATTERN_WORD(PWORD)
  ) dut (
    .i_clk(i_clk),
    .i_rst_n(i_rst_n),
    .i_pat_req(i_pat_req),
    .o_pat_ack(o_pat_ack),
    .i_rdi_req(i_rdi_req),
    .i_rdi_hdr(i_rdi_hdr),
    .o_rdi_ack(o_rdi_ack),
    .i_ltsm_req(i_ltsm_req),
    .i_ltsm_has_data(i_ltsm_has_data),
    .i_ltsm_hdr(i_ltsm_hdr),
    .i_ltsm_data(i_ltsm_data),
    .o_ltsm_ack(o_ltsm_ack),
    .o_ser_data(o_ser_data),
    .o_ser_valid(o_ser_valid),
    .i_ser_done(i_ser_done),
    .o_busy(o_busy)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance to the next falling edge; i_ser_done is only ever a 1-cycle pulse.
  task automatic tick();
    @(negedge i_clk);
    i_ser_done = 1'b0;
  endtask

  task automatic applyStimulus(input bit p, input bit r, input bit l);
    i_pat_req  = p;
    i_rdi_req  = r;
    i_ltsm_req = l;
  endtask

  function automatic logic [63:0] rand64();
    return {$urandom, $urandom};
  endfunction

  // Arbitration model: pattern first, then whoever the round-robin favours.
  function automatic int pickWinner(input bit p, input bit r, input bit l);
    if (p) return SRC_PAT;
    if (r && l) return rrNext;
    if (r) return SRC_RDI;
    if (l) return SRC_LTSM;
    return SRC_NONE;
  endfunction

  task automatic checkAcks(input string tag, input int expSrc);
    checkOutput({tag, "_pat_ack"},  o_pat_ack,  expSrc == SRC_PAT);
    checkOutput({tag, "_rdi_ack"},  o_rdi_ack,  expSrc == SRC_RDI);
    checkOutput({tag, "_ltsm_ack"}, o_ltsm_ack, expSrc == SRC_LTSM);
  endtask

  task automatic waitValid(output int cyc);
    cyc = 0;
    while (!o_ser_valid && cyc < 40) begin
      tick();
      cyc++;
    end
  endtask

  task automatic waitIdle(output int cyc);
    cyc = 0;
    while (o_busy && cyc < 40) begin
      tick();
      cyc++;
    end
  endtask

  // Serve one packet from source src. Word list is taken from the request
  // inputs at call time. expLat is the expected number of falling edges until
  // the first valid (-1 skips that check). Ends on the edge of the last done.
  task automatic servePacket(input int src, input int expLat, input bit sendDone, input bit mutate);
    logic [63:0] w [2];
    int          n;
    int          cyc;
    case (src)
      SRC_PAT:  begin n = PW; w[0] = PWORD; w[1] = PWORD; end
      SRC_RDI:  begin n = 1; w[0] = i_rdi_hdr; w[1] = 64'd0; end
      default:  begin n = i_ltsm_has_data ? 2 : 1; w[0] = i_ltsm_hdr; w[1] = i_ltsm_data; end
    endcase
    for (int k = 0; k < n; k++) begin
      if (k == 0) begin
        waitValid(cyc);
      end else begin
        tick();
        cyc = 1;
      end
      checkOutput("valid_seen", o_ser_valid, 1'b1);
      if (!o_ser_valid) return;
      if (k == 0 && expLat >= 0) checkOutput("grant_latency", cyc, expLat);
      checkOutput("word", o_ser_data, w[k]);
      if (k == 0 && sendDone) begin
        i_ser_done = 1'b1;
        #1;
        checkAcks("send_done", SRC_NONE);
      end
      tick();
      checkOutput("valid_pulse", o_ser_valid, 1'b0);
      if (k == 0 && mutate) begin
        applyStimulus(1'b0, 1'b0, 1'b0);
        i_rdi_hdr   = rand64();
        i_ltsm_hdr  = rand64();
        i_ltsm_data = rand64();
      end
      repeat ($urandom_range(0, 3)) tick();
      checkOutput("held_word", o_ser_data, w[k]);
      i_ser_done = 1'b1;
      #1;
      checkAcks("done", (k == n - 1) ? src : SRC_NONE);
    end
  endtask

  // Serve every pending request in model order, starting from an idle DUT.
  task automatic drainRequests();
    int  win;
    bit  first = 1'b1;
    int  cyc;
    while (i_pat_req || i_rdi_req || i_ltsm_req) begin
      win = pickWinner(i_pat_req, i_rdi_req, i_ltsm_req);
      servePacket(win, first ? 1 : GAP + 2, ($urandom_range(0, 3) == 0), 1'b0);
      case (win)
        SRC_PAT:  i_pat_req = 1'b0;
        SRC_RDI:  begin i_rdi_req = 1'b0;  rrNext = SRC_LTSM; end
        default:  begin i_ltsm_req = 1'b0; rrNext = SRC_RDI;  end
      endcase
      first = 1'b0;
    end
    waitIdle(cyc);
    checkOutput("drain_idle", o_busy, 1'b0);
  endtask

  initial begin
    int cyc;
    i_rst_n = 1'b0;
    i_ser_done = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0);
    i_rdi_hdr = 64'd0;
    i_ltsm_has_data = 1'b0;
    i_ltsm_hdr = 64'd0;
    i_ltsm_data = 64'd0;
    repeat (3) tick();
    checkOutput("rst_ser_data", o_ser_data, 64'd0);
    checkOutput("rst_ser_valid", o_ser_valid, 1'b0);
    checkOutput("rst_busy", o_busy, 1'b0);
    checkAcks("rst", SRC_NONE);
    i_rst_n = 1'b1;
    tick();

    // Done while idle must not start anything.
    i_ser_done = 1'b1;
    #1;
    checkAcks("idle_done", SRC_NONE);
    tick();
    checkOutput("idle_done_busy", o_busy, 1'b0);
    checkOutput("idle_done_valid", o_ser_valid, 1'b0);

    // Pattern burst, then busy drops GAP+1 cycles after the final done.
    applyStimulus(1'b1, 1'b0, 1'b0);
    servePacket(SRC_PAT, 1, 1'b0, 1'b0);
    i_pat_req = 1'b0;
    waitIdle(cyc);
    checkOutput("pat_busy_clear", cyc, GAP + 1);

    // LTSM with and without data word.
    i_ltsm_hdr = 64'h0000_0002_00A5_0012;
    i_ltsm_data = 64'h1234;
    i_ltsm_has_data = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b1);
    drainRequests();
    i_ltsm_has_data = 1'b0;
    i_ltsm_hdr = 64'h0000_0002_00A5_0013;
    applyStimulus(1'b0, 1'b0, 1'b1);
    servePacket(SRC_LTSM, 1, 1'b1, 1'b0);
    i_ltsm_req = 1'b0;
    rrNext = SRC_RDI;
    waitIdle(cyc);

    // Every requester at once, then random mixes with held levels.
    for (int round = 0; round < 10; round++) begin
      bit p, r, l;
      p = (round == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      r = (round <= 1) ? 1'b1 : 1'($urandom_range(0, 1));
      l = (round <= 1) ? 1'b1 : 1'($urandom_range(0, 1));
      if (!p && !r && !l) r = 1'b1;
      i_rdi_hdr = rand64();
      i_ltsm_hdr = rand64();
      i_ltsm_data = rand64();
      i_ltsm_has_data = 1'($urandom_range(0, 1));
      applyStimulus(p, r, l);
      drainRequests();
    end

    // Inputs change mid-packet; captured words must still go out.
    i_ltsm_has_data = 1'b1;
    i_ltsm_hdr = rand64();
    i_ltsm_data = rand64();
    applyStimulus(1'b0, 1'b0, 1'b1);
    servePacket(SRC_LTSM, 1, 1'b0, 1'b1);
    rrNext = SRC_RDI;
    waitIdle(cyc);
    i_rdi_hdr = rand64();
    applyStimulus(1'b0, 1'b1, 1'b0);
    servePacket(SRC_RDI, 1, 1'b0, 1'b1);
    rrNext = SRC_LTSM;
    // Spurious done in GAP is ignored and does not shorten the gap.
    tick();
    i_ser_done = 1'b1;
    #1;
    checkAcks("gap_done", SRC_NONE);
    waitIdle(cyc);
    checkOutput("gap_done_busy_clear", cyc + 1, GAP + 1);
    checkOutput("gap_done_no_valid", o_ser_valid, 1'b0);

    // Reset while the data word is in flight.
    i_ltsm_has_data = 1'b1;
    i_ltsm_hdr = rand64();
    i_ltsm_data = rand64();
    applyStimulus(1'b0, 1'b0, 1'b1);
    waitValid(cyc);
    checkOutput("rst_pkt_hdr", o_ser_data, i_ltsm_hdr);
    tick();
    i_ser_done = 1'b1;
    tick();
    checkOutput("rst_pkt_data", o_ser_data, i_ltsm_data);
    tick();
    i_rst_n = 1'b0;
    i_ser_done = 1'b1;
    #1;
    checkOutput("midrst_ser_data", o_ser_data, 64'd0);
    checkOutput("midrst_valid", o_ser_valid, 1'b0);
    checkOutput("midrst_busy", o_busy, 1'b0);
    checkAcks("midrst", SRC_NONE);
    tick();
    rrNext = SRC_RDI;
    i_ltsm_has_data = 1'b0;
    i_ltsm_hdr = rand64();
    i_rst_n = 1'b1;
    servePacket(SRC_LTSM, 1, 1'b0, 1'b0);
    i_ltsm_req = 1'b0;
    waitIdle(cyc);
    checkOutput("final_idle", o_busy, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
